// File: rtl/pwm_regs_pkg.sv
// Register map constants and bit positions for the PWM duty register bank.
package pwm_regs_pkg;

  localparam logic [3:0] ADDR_SHADOW0 = 4'd0;
  localparam logic [3:0] ADDR_CTRL    = 4'd9;
  localparam logic [3:0] ADDR_STEP    = 4'd10;
  localparam logic [3:0] ADDR_STATUS  = 4'd11;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_RAMP_EN = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int ST_PENDING = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_DONE    = 2;

endpackage

// File: rtl/pwm_ramp_ch.sv
// One PWM channel: target/active pair, updated only on period_sync, either
// snapping to the target or slewing toward it by at most STEP per period.
module pwm_ramp_ch
  import pwm_regs_pkg::*;
#(
  parameter int RESOLUTION = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  period_sync,
  input  logic                  load,
  input  logic [RESOLUTION-1:0] load_val,
  input  logic                  immediate,
  input  logic [RESOLUTION-1:0] step,
  output logic [RESOLUTION-1:0] active,
  output logic                  at_target
);

  logic [RESOLUTION-1:0] target;
  logic [RESOLUTION-1:0] target_d;
  logic [RESOLUTION-1:0] active_d;
  logic [RESOLUTION-1:0] ramp_val;
  logic [RESOLUTION:0]   diff;
  logic [RESOLUTION:0]   mag;

  // The ramp on a latching sync already heads for the newly loaded target.
  always_comb begin
    target_d = target;
    if (period_sync && load) target_d = load_val;

    diff = {1'b0, target_d} - {1'b0, active};
    mag  = diff[RESOLUTION] ? -diff : diff;

    ramp_val = target_d;
    if (mag > {1'b0, step})
      ramp_val = diff[RESOLUTION] ? (active - step) : (active + step);

    active_d = active;
    if (period_sync) active_d = immediate ? target_d : ramp_val;
  end

  // Post-update comparison; equals the registered compare outside sync cycles.
  assign at_target = (active_d == target_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
      active <= '0;
    end else begin
      target <= target_d;
      active <= active_d;
    end
  end

endmodule

// File: rtl/pwm_duty_regs.sv
// Avalon-MM register bank holding double-buffered PWM duties; commits land on
// PWM period boundaries, optionally slew-limited.
module pwm_duty_regs
  import pwm_regs_pkg::*;
#(
  parameter int RESOLUTION = 16,
  parameter int NUM_CH     = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   avs_address,
  input  logic                         avs_write,
  input  logic [31:0]                  avs_writedata,
  input  logic                         avs_read,
  output logic [31:0]                  avs_readdata,
  input  logic                         period_sync,
  output logic [NUM_CH*RESOLUTION-1:0] duty_bus,
  output logic                         irq
);

  logic [NUM_CH-1:0][RESOLUTION-1:0] shadow;
  logic [NUM_CH-1:0]                 at_target;
  logic [RESOLUTION-1:0]             step;
  logic [RESOLUTION-1:0]             wdata;
  logic                              ramp_en;
  logic                              irq_en;
  logic                              pending;
  logic                              busy;
  logic                              done;
  logic                              all_next;
  logic                              commit_wr;
  logic                              done_clr;
  logic                              done_set;
  logic                              load;
  logic                              immediate;
  logic [31:0]                       rd_mux;
  logic                              unused_wdata;

  assign wdata        = avs_writedata[RESOLUTION-1:0];
  assign unused_wdata = ^avs_writedata[31:RESOLUTION];

  assign commit_wr = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[CTRL_COMMIT];
  assign done_clr  = avs_write && (avs_address == ADDR_STATUS) && avs_writedata[ST_DONE];
  assign load      = period_sync && pending;
  assign immediate = !ramp_en || (step == '0);
  assign all_next  = &at_target;

  // A commit arriving with the sync keeps PENDING set, so DONE must wait for it too.
  assign done_set  = period_sync && (pending || busy) && all_next && !commit_wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        shadow[i] <= '0;
      else if (avs_write && (avs_address == 4'(ADDR_SHADOW0 + i)))
        shadow[i] <= wdata;
    end

    pwm_ramp_ch #(.RESOLUTION(RESOLUTION)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .period_sync (period_sync),
      .load        (load),
      .load_val    (shadow[i]),
      .immediate   (immediate),
      .step        (step),
      .active      (duty_bus[i*RESOLUTION +: RESOLUTION]),
      .at_target   (at_target[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_en <= 1'b0;
      irq_en  <= 1'b0;
      step    <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (avs_write && (avs_address == ADDR_CTRL)) begin
        ramp_en <= avs_writedata[CTRL_RAMP_EN];
        irq_en  <= avs_writedata[CTRL_IRQ_EN];
      end
      if (avs_write && (avs_address == ADDR_STEP)) step <= wdata;

      if (commit_wr)        pending <= 1'b1;
      else if (period_sync) pending <= 1'b0;

      busy <= !all_next;

      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;

      irq <= done && irq_en;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (avs_address == 4'(ADDR_SHADOW0 + i)) rd_mux = 32'(shadow[i]);
    case (avs_address)
      ADDR_CTRL: begin
        rd_mux[CTRL_RAMP_EN] = ramp_en;
        rd_mux[CTRL_IRQ_EN]  = irq_en;
      end
      ADDR_STEP:   rd_mux = 32'(step);
      ADDR_STATUS: begin
        rd_mux[ST_PENDING] = pending;
        rd_mux[ST_BUSY]    = busy;
        rd_mux[ST_DONE]    = done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
    else               avs_readdata <= '0;
  end

endmodule
